vga_write_arbiter: RTL

//  Shares the single VGA adapter write port between the player and bee datapaths.

---
 rtl/vga_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/vga_write_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vga_arb_pkg.sv
// Shared constants and types for the VGA write-port arbiter and its neighbours.
//   Default widths, screen geometry, background colour and the arbiter FSM state type.
package vga_arb_pkg;

    localparam int unsigned DEF_NUM_REQ  = 4;
    localparam int unsigned DEF_X_W      = 7;
    localparam int unsigned DEF_Y_W      = 7;
    localparam int unsigned DEF_COLOR_W  = 3;
    localparam int unsigned DEF_SCREEN_W = 128;
    localparam int unsigned DEF_SCREEN_H = 120;
    localparam logic [DEF_COLOR_W-1:0] DEF_BG_COLOR = 3'b000;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_ERASE = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search.
//   req    : per-requester request bits
//   ptr    : index with highest priority this cycle
//   grant  : one-hot winner (all zero when no request)
//   winner : index of the winning requester
//   valid  : at least one request present
module rr_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    // Walk from ptr upwards (mod NUM_REQ); the first asserted request wins.
    always_comb begin
        int unsigned idx;
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr) + off) % NUM_REQ;
            if (!valid && req[PTR_W'(idx)]) begin
                grant[PTR_W'(idx)] = 1'b1;
                winner             = PTR_W'(idx);
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the VGA adapter write port between the player and bee datapaths.
// Grants one plot request per cycle round-robin and registers the winner's
// x/y/colour onto the adapter port; on erase_req sweeps the whole screen with
// the background colour while blocking all requesters.
//   clk, reset        : clock, asynchronous active-high reset
//   req/req_x/y/color : packed per-requester plot requests (slice i = [i*W +: W])
//   grant             : one-hot accept, combinational from req while arbitrating
//   erase_req         : start full-screen erase (sampled while arbitrating)
//   erase_done        : pulses with the plot of the last erase pixel
//   busy              : high while the erase sweep runs
//   vga_x/y/colour/plot : registered adapter write port
module vga_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned X_W      = DEF_X_W,
    parameter int unsigned Y_W      = DEF_Y_W,
    parameter int unsigned COLOR_W  = DEF_COLOR_W,
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H,
    parameter logic [COLOR_W-1:0] BG_COLOR = DEF_BG_COLOR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    output logic [NUM_REQ-1:0]         grant,
    input  logic                       erase_req,
    output logic                       erase_done,
    output logic                       busy,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COLOR_W-1:0]         vga_colour,
    output logic                       vga_plot
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned EX_W  = $clog2(SCREEN_W);
    localparam int unsigned EY_W  = $clog2(SCREEN_H);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [EX_W-1:0]    ex_q, ex_d;
    logic [EY_W-1:0]    ey_q, ey_d;
    logic [X_W-1:0]     vga_x_d;
    logic [Y_W-1:0]     vga_y_d;
    logic [COLOR_W-1:0] vga_colour_d;
    logic               vga_plot_d;
    logic               erase_done_d;
    logic               busy_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_winner;
    logic               arb_valid;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COLOR_W-1:0] sel_color;
    logic               sel_on_screen;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req    (req),
        .ptr    (rr_ptr_q),
        .grant  (arb_grant),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Winner's payload slice and its visibility.
    assign sel_x         = req_x[32'(arb_winner) * X_W +: X_W];
    assign sel_y         = req_y[32'(arb_winner) * Y_W +: Y_W];
    assign sel_color     = req_color[32'(arb_winner) * COLOR_W +: COLOR_W];
    assign sel_on_screen = (32'(sel_x) < SCREEN_W) && (32'(sel_y) < SCREEN_H);

    // Next-state, grant and next output values.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        ex_d         = ex_q;
        ey_d         = ey_q;
        vga_x_d      = vga_x;
        vga_y_d      = vga_y;
        vga_colour_d = vga_colour;
        vga_plot_d   = 1'b0;
        erase_done_d = 1'b0;
        busy_d       = 1'b0;
        grant        = '0;

        case (state_q)
            ST_ARB: begin
                if (erase_req) begin
                    // Erase takes priority; same-cycle requests wait.
                    state_d = ST_ERASE;
                    ex_d    = '0;
                    ey_d    = '0;
                    busy_d  = 1'b1;
                end else if (arb_valid && !reset) begin
                    grant        = arb_grant;
                    rr_ptr_d     = (arb_winner == PTR_W'(NUM_REQ - 1)) ? '0
                                                                       : arb_winner + PTR_W'(1);
                    vga_x_d      = sel_x;
                    vga_y_d      = sel_y;
                    vga_colour_d = sel_color;
                    vga_plot_d   = sel_on_screen;
                end
            end

            ST_ERASE: begin
                vga_x_d      = X_W'(ex_q);
                vga_y_d      = Y_W'(ey_q);
                vga_colour_d = BG_COLOR;
                vga_plot_d   = 1'b1;
                busy_d       = 1'b1;
                if (ex_q == EX_W'(SCREEN_W - 1)) begin
                    ex_d = '0;
                    if (ey_q == EY_W'(SCREEN_H - 1)) begin
                        // Last pixel issued on this edge.
                        ey_d         = '0;
                        state_d      = ST_ARB;
                        erase_done_d = 1'b1;
                        busy_d       = 1'b0;
                    end else begin
                        ey_d = ey_q + EY_W'(1);
                    end
                end else begin
                    ex_d = ex_q + EX_W'(1);
                end
            end

            default: state_d = ST_ARB;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            ex_q       <= '0;
            ey_q       <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            erase_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            ex_q       <= ex_d;
            ey_q       <= ey_d;
            vga_x      <= vga_x_d;
            vga_y      <= vga_y_d;
            vga_colour <= vga_colour_d;
            vga_plot   <= vga_plot_d;
            erase_done <= erase_done_d;
            busy       <= busy_d;
        end
    end

endmodule
